// File: rtl/icache_refill_ctrl.sv
// Miss-handling controller for an 8-line direct-mapped I-cache: lookup, 4-beat refill, line write.
// Optional critical-word-first beat ordering is enabled by defining ICACHE_CWF_EN.
module icache_refill_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             fetch_req_i,
   input  logic [31:0]      fetch_addr_i,
   output logic             fetch_ready_o,
   output logic             fetch_done_o,
   output logic [31:0]      cache_addr_o,
   input  logic             cache_hit_i,
   output logic             fill_we_o,
   output logic [127:0]     fill_data_o,
   output logic             mem_req_o,
   output logic [31:0]      mem_addr_o,
   input  logic             mem_ack_i,
   input  logic [31:0]      mem_rdata_i,
   output logic [CNT_W-1:0] miss_count_o
);

   typedef enum logic [2:0] {StIdle, StLookup, StCheck, StRefill, StWrite} state_e;

   state_e             state_q, state_d;
   logic [31:0]        cache_addr_q, cache_addr_d;
   logic [127:0]       fill_data_q, fill_data_d;
   logic [1:0]         beat_q, beat_d;
   logic [1:0]         nbeats_q, nbeats_d;
   logic [CNT_W-1:0]   miss_q, miss_d;
   logic [1:0]         first_beat;

`ifdef ICACHE_CWF_EN
   assign first_beat = cache_addr_q[3:2];
`else
   assign first_beat = 2'd0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         cache_addr_q <= '0;
         fill_data_q  <= '0;
         beat_q       <= '0;
         nbeats_q     <= '0;
         miss_q       <= '0;
      end else begin
         state_q      <= state_d;
         cache_addr_q <= cache_addr_d;
         fill_data_q  <= fill_data_d;
         beat_q       <= beat_d;
         nbeats_q     <= nbeats_d;
         miss_q       <= miss_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cache_addr_d = cache_addr_q;
      fill_data_d  = fill_data_q;
      beat_d       = beat_q;
      nbeats_d     = nbeats_q;
      miss_d       = miss_q;
      unique case (state_q)
         StIdle: begin
            if (fetch_req_i) begin
               cache_addr_d = fetch_addr_i;
               state_d      = StLookup;
            end
         end
         StLookup: state_d = StCheck;
         StCheck: begin
            if (cache_hit_i) begin
               state_d = StIdle;
            end else begin
               if (miss_q != {CNT_W{1'b1}}) miss_d = miss_q + 1'b1;
               beat_d   = first_beat;
               nbeats_d = 2'd0;
               state_d  = StRefill;
            end
         end
         StRefill: begin
            if (mem_ack_i) begin
               fill_data_d[32*beat_q +: 32] = mem_rdata_i;
               beat_d   = beat_q + 2'd1;
               nbeats_d = nbeats_q + 2'd1;
               if (nbeats_q == 2'd3) state_d = StWrite;
            end
         end
         StWrite: state_d = StLookup;
         default: state_d = StIdle;
      endcase
   end

   // Outputs decode straight from state so an async reset drops them at once.
   assign fetch_ready_o = (state_q == StIdle) && rst_ni;
   assign fetch_done_o  = (state_q == StCheck) && cache_hit_i;
   assign fill_we_o     = (state_q == StWrite);
   assign mem_req_o     = (state_q == StRefill);
   assign mem_addr_o    = mem_req_o ? {cache_addr_q[31:4], beat_q, 2'b00} : 32'h0;
   assign cache_addr_o  = cache_addr_q;
   assign fill_data_o   = fill_data_q;
   assign miss_count_o  = miss_q;

endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Miss-handling controller for the 8-line direct-mapped instruction cache (128-bit lines, 25-bit tag, address bits [6:4] index, [3:2] word offset). It accepts fetch requests from the IF stage and drives the cache lookup address. On a miss it fetches the 4-word line from main memory over a 32-bit request/ack port, assembles the line and writes it into the cache. It then re-runs the lookup, so the IF stage always receives its instruction from the cache.

## Interface
- CNT_W, 16, width of the saturating miss counter
- Clk  in  1  system clock, all state on rising edge
- Rst_n  in  1  asynchronous active-low reset
- fetch_req  in  1  IF stage requests instruction at fetch_addr
- fetch_addr  in  32  byte address; bits [1:0] ignored
- fetch_ready  out  1  controller can accept a request (IDLE only)
- fetch_done  out  1  one-cycle pulse; cache inst output valid this cycle
- cache_addr  out  32  registered lookup/fill address to cache
- cache_hit  in  1  cache hit flag, registered by cache on Clk
- fill_we  out  1  one-cycle line-write strobe
- fill_data  out  128  assembled line, word 0 in [31:0]
- mem_req  out  1  memory beat request
- mem_addr  out  32  word-aligned beat address
- mem_ack  in  1  beat accepted; mem_rdata valid same cycle
- mem_rdata  in  32  beat data
- miss_count  out  CNT_W  number of misses since reset, saturating

## Operation
- States: IDLE, LOOKUP, CHECK, REFILL, WRITE.
- IDLE: fetch_ready=1. When fetch_req=1, latch fetch_addr into cache_addr and go to LOOKUP.
- LOOKUP: wait one cycle. The cache samples cache_addr on the closing edge.
- CHECK, cache_hit=1: pulse fetch_done and go to IDLE.
- CHECK, cache_hit=0: increment miss_count (saturates at 2^CNT_W-1), clear the beat counter, assert mem_req and go to REFILL.
- REFILL: mem_addr = {cache_addr[31:4], beat_idx, 2'b00}. mem_req stays high and mem_addr stays stable until mem_ack=1. On each ack edge, store mem_rdata into word slot beat_idx and advance the 2-bit beat counter. mem_req stays high across beats. After the 4th ack, drop mem_req and go to WRITE.
- WRITE: fill_we=1 for exactly one cycle with fill_data complete and cache_addr unchanged, then go to LOOKUP. The second lookup is required to hit.
- fill_data holds its value outside WRITE. The cache must act on fill_we only.
- fetch_req is ignored outside IDLE. fetch_addr may change freely once the request is accepted.
- A second consecutive miss on the same address (CHECK after WRITE with cache_hit=0) is a protocol error. The controller refills again; no special handling.

## Timing
- Reset values: fetch_ready=0 while Rst_n=0, and 1 in the first cycle after release (IDLE). fetch_done=0, cache_addr=0, fill_we=0, fill_data=0, mem_req=0, mem_addr=0, miss_count=0.
- Hit latency: request accepted at edge 0, fetch_done high in cycle 2 (after edge 2).
- Miss latency with mem_ack tied high: accept edge 0, CHECK cycle 2, REFILL cycles 3-6, WRITE cycle 7, LOOKUP cycle 8, fetch_done cycle 9.
- Each additional wait cycle on mem_ack adds one cycle to the miss latency.
- Back-to-back: fetch_ready returns in the cycle after fetch_done, so one idle cycle is the minimum between requests.
- Reset asserted mid-REFILL or in WRITE: return to IDLE immediately. The partial line is discarded, fill_we is never asserted, and mem_req drops asynchronously.
- mem_ack while mem_req=0 is ignored.

## Configuration
- ICACHE_CWF_EN defined (critical word first): on a miss the beat counter starts at cache_addr[3:2] and wraps modulo 4. For example, offset 2 issues beats in the order 2,3,0,1. Latency is unchanged, since the line is still written only in WRITE.
- ICACHE_CWF_EN undefined: beats always issue in the order 0,1,2,3.

## Test plan
- Reset, then request 0x0000_0040 with the cache cold -> one miss. mem_addr sequence 0x40, 0x44, 0x48, 0x4C. fill_we for one cycle with fill_data = {w3,w2,w1,w0}. fetch_done in cycle 9. miss_count=1.
- Repeat request 0x0000_0044 -> hit. fetch_done in cycle 2, no mem_req, miss_count stays 1.
- Request 0x0000_0848 (same index, new tag) with mem_ack delayed 3 cycles per beat -> mem_addr held stable during each wait. fetch_done at cycle 9+12=21.
- ICACHE_CWF_EN build, miss on 0x0000_0108 -> beats 0x108, 0x10C, 0x100, 0x104. fill_data word order is still by offset.
- Drop Rst_n after the 2nd ack of a refill -> all outputs 0 immediately and no fill_we. After release, the same request refills again from beat 0.
- CNT_W=2, five distinct misses -> miss_count saturates at 3.
